// File: rtl/sdram_arbit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbit_pkg
// Description : Shared definitions for the SDRAM controller family: arbiter
//               FSM state encoding, grant encoding, SDRAM command codes
//               {cs_n,ras_n,cas_n,we_n}, idle bank/address values and bus
//               widths. Used by the arbiter and the init/aref/wr/rd
//               controllers.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arbit_pkg;

    // Bus widths
    localparam int CMD_W  = 4;
    localparam int BA_W   = 2;
    localparam int ADDR_W = 13;
    localparam int DQ_W   = 16;

    // SDRAM command codes {cs_n, ras_n, cas_n, we_n}
    localparam logic [CMD_W-1:0] CMD_NOP        = 4'b0111;
    localparam logic [CMD_W-1:0] CMD_PRECHARGE  = 4'b0010;
    localparam logic [CMD_W-1:0] CMD_AUTO_REF   = 4'b0001;
    localparam logic [CMD_W-1:0] CMD_M_REG_SET  = 4'b0000;
    localparam logic [CMD_W-1:0] CMD_ACTIVE     = 4'b0011;
    localparam logic [CMD_W-1:0] CMD_WRITE      = 4'b0100;
    localparam logic [CMD_W-1:0] CMD_READ       = 4'b0101;
    localparam logic [CMD_W-1:0] CMD_BURST_STOP = 4'b0110;

    // Values driven while no controller owns the bus
    localparam logic [BA_W-1:0]   C_IDLE_BA   = 2'b11;
    localparam logic [ADDR_W-1:0] C_IDLE_ADDR = 13'h1fff;

    // Arbiter FSM state encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } arb_state_t;

    // Last data-transfer grant, used for write/read round-robin
    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

endpackage : sdram_arbit_pkg
`default_nettype wire

// File: rtl/sdram_arbit.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arbit
// Description : SDRAM bus arbiter. Holds the bus for the init controller
//               until init_end, then grants it to refresh (highest priority)
//               or write/read (round-robin when both request). The owning
//               controller keeps the bus until its end pulse.
// Ports       : sys_clk/sys_rst_n  - clock, async active-high reset
//               init_*/aref_*/wr_*/rd_* - per-controller request, end pulse
//                                    and command/bank/address bus
//               aref_en/wr_en/rd_en - grants (decoded from state)
//               sdram_*             - muxed pins to the SDRAM device
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter logic [CMD_W-1:0]  NOP       = CMD_NOP,
    parameter logic [BA_W-1:0]   IDLE_BA   = C_IDLE_BA,
    parameter logic [ADDR_W-1:0] IDLE_ADDR = C_IDLE_ADDR
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,      // active-high despite the name
    input  logic              init_end,
    input  logic [CMD_W-1:0]  init_cmd,
    input  logic [BA_W-1:0]   init_ba,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [CMD_W-1:0]  aref_cmd,
    input  logic [BA_W-1:0]   aref_ba,
    input  logic [ADDR_W-1:0] aref_addr,
    input  logic              wr_req,
    input  logic              wr_end,
    input  logic [CMD_W-1:0]  wr_cmd,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_sdram_en,
    input  logic [DQ_W-1:0]   wr_sdram_data,
    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [CMD_W-1:0]  rd_cmd,
    input  logic [BA_W-1:0]   rd_ba,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,
    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BA_W-1:0]   sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DQ_W-1:0]   sdram_dq_out,
    output logic              sdram_dq_oe
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;

    logic [CMD_W-1:0] cmd_mux;

    // State and round-robin history
    always_ff @(posedge sys_clk or posedge sys_rst_n) begin
        if (sys_rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_READ;   // so WRITE wins the first tie
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next state. Every owner returns to ARBIT on its end pulse, and ARBIT
    // only grants on the following edge, which guarantees one idle ARBIT
    // cycle between consecutive grants.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            ST_IDLE: begin
                if (init_end) state_d = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (aref_req) begin
                    state_d = ST_AREF;
                end else if (wr_req && rd_req) begin
                    if (last_grant_q == GRANT_READ) begin
                        state_d      = ST_WRITE;
                        last_grant_d = GRANT_WRITE;
                    end else begin
                        state_d      = ST_READ;
                        last_grant_d = GRANT_READ;
                    end
                end else if (wr_req) begin
                    state_d      = ST_WRITE;
                    last_grant_d = GRANT_WRITE;
                end else if (rd_req) begin
                    state_d      = ST_READ;
                    last_grant_d = GRANT_READ;
                end
            end
            ST_AREF: begin
                if (aref_end) state_d = ST_ARBIT;
            end
            ST_WRITE: begin
                if (wr_end) state_d = ST_ARBIT;
            end
            ST_READ: begin
                if (rd_end) state_d = ST_ARBIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus mux and grant decode
    always_comb begin
        cmd_mux      = NOP;
        sdram_ba     = IDLE_BA;
        sdram_addr   = IDLE_ADDR;
        aref_en      = 1'b0;
        wr_en        = 1'b0;
        rd_en        = 1'b0;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = '0;
        unique case (state_q)
            ST_IDLE: begin
                cmd_mux    = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            ST_AREF: begin
                aref_en    = 1'b1;
                cmd_mux    = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            ST_WRITE: begin
                wr_en        = 1'b1;
                cmd_mux      = wr_cmd;
                sdram_ba     = wr_ba;
                sdram_addr   = wr_addr;
                sdram_dq_oe  = wr_sdram_en;
                sdram_dq_out = wr_sdram_data;
            end
            ST_READ: begin
                rd_en      = 1'b1;
                cmd_mux    = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: ;   // ARBIT: NOP with idle bank/address
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
    assign sdram_cke = 1'b1;

endmodule : sdram_arbit
`default_nettype wire
